// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared constants and types for the Kyber polynomial datapath:
//   - polynomial length, modulus, CBD sampler lane count and coefficient width
//   - collector FSM state encoding
//   - helper to flag the out-of-range raw CBD code (-4)
// -----------------------------------------------------------------------------
package kyber_pkg;

    localparam int KYBER_N   = 256;
    localparam int KYBER_Q   = 3329;
    localparam int CBD_LANES = 7;
    localparam int CBD_CW    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READY   = 2'd2
    } col_state_e;

    // The only 3-bit two's-complement code outside -3..3 is 3'b100.
    function automatic logic cbd_code_illegal(input logic [CBD_CW-1:0] code);
        return (code == 3'b100);
    endfunction

endpackage

// File: rtl/cbd_to_modq.sv
// -----------------------------------------------------------------------------
// cbd_to_modq
// Combinational mapper from a raw 3-bit signed CBD coefficient to its
// representative in [0, Q-1], zero-extended to 12 bits.
//   coef_i : raw signed coefficient (-4..3)
//   modq_o : v for v >= 0, Q + v for v < 0
// -----------------------------------------------------------------------------
module cbd_to_modq
    import kyber_pkg::*;
#(
    parameter int Q  = KYBER_Q,
    parameter int CW = CBD_CW
) (
    input  logic [CW-1:0] coef_i,
    output logic [11:0]   modq_o
);

    logic [CW-1:0] mag_s;

    // Negative inputs become Q - |v|; non-negative inputs pass through.
    always_comb begin
        mag_s  = {CW{1'b0}};
        modq_o = 12'd0;
        if (coef_i[CW-1]) begin
            // Magnitude of the negative value; 3'b100 yields 4 as required.
            mag_s  = CW'(~coef_i + {{(CW-1){1'b0}}, 1'b1});
            modq_o = 12'(Q) - {{(12-CW){1'b0}}, mag_s};
        end else begin
            mag_s  = coef_i;
            modq_o = {{(12-CW){1'b0}}, coef_i};
        end
    end

endmodule

// File: rtl/cbd_poly_collector.sv
// -----------------------------------------------------------------------------
// cbd_poly_collector
// Receives bursts of signed CBD coefficients, packs them in arrival order into
// a 256-entry polynomial buffer and flags completion on the sampler done pulse.
// A 1-cycle-latency read port returns stored coefficients mapped to [0, Q-1].
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_start        : arm / restart collection
//   i_coef, i_num  : packed lanes (lane k at [3k+2:3k]) and valid lane count
//   i_done         : sampler done pulse
//   i_rd_en/addr   : read request, o_rd_data/o_rd_valid one cycle later
//   o_cnt          : coefficients stored (saturates at 256)
//   o_busy         : collecting
//   o_valid        : complete, error-free polynomial held
//   o_err          : sticky protocol error (overflow, short stream, -4 lane)
// -----------------------------------------------------------------------------
module cbd_poly_collector
    import kyber_pkg::*;
#(
    parameter int N_COEF = KYBER_N,
    parameter int Q      = KYBER_Q,
    parameter int LANES  = CBD_LANES,
    parameter int CW     = CBD_CW
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [LANES*CW-1:0]   i_coef,
    input  logic [2:0]            i_num,
    input  logic                  i_done,
    input  logic                  i_rd_en,
    input  logic [7:0]            i_rd_addr,
    output logic [11:0]           o_rd_data,
    output logic                  o_rd_valid,
    output logic [8:0]            o_cnt,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_err
);

    localparam logic [9:0] CNT_FULL = 10'(N_COEF);

    col_state_e    state_q, state_d;
    logic [8:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;
    logic          busy_q;
    logic [CW-1:0] mem_q [N_COEF];
    logic [11:0]   rd_data_q;
    logic          rd_valid_q;

    logic             collect_wr_s;
    logic [9:0]       sum_s;
    logic [LANES-1:0] lane_wen_s;
    logic [7:0]       lane_addr_s [LANES];
    logic [CW-1:0]    lane_val_s  [LANES];
    logic             bad_lane_s;
    logic [9:0]       lane_idx_s;
    logic [11:0]      rd_map_s;

    // Lane steering: lane j targets cnt+j; lanes past the end are dropped.
    always_comb begin
        collect_wr_s = (state_q == ST_COLLECT) && !i_start;
        sum_s        = {1'b0, cnt_q} + 10'(i_num);
        bad_lane_s   = 1'b0;
        lane_idx_s   = 10'd0;
        for (int j = 0; j < LANES; j++) begin
            lane_idx_s     = {1'b0, cnt_q} + 10'(j);
            lane_val_s[j]  = i_coef[CW*j +: CW];
            lane_addr_s[j] = lane_idx_s[7:0];
            if (collect_wr_s && (3'(j) < i_num)) begin
                lane_wen_s[j] = (lane_idx_s < CNT_FULL);
                bad_lane_s    = bad_lane_s | cbd_code_illegal(lane_val_s[j]);
            end else begin
                lane_wen_s[j] = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a start pulse always wins over done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_COLLECT;
                else         state_d = ST_IDLE;
            end
            ST_COLLECT: begin
                if (i_start)     state_d = ST_COLLECT;
                else if (i_done) state_d = ST_READY;
                else             state_d = ST_COLLECT;
            end
            ST_READY: begin
                if (i_start) state_d = ST_COLLECT;
                else         state_d = ST_READY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: count, sticky error and completion flag.
    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (i_start) begin
                    cnt_d   = 9'd0;
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_COLLECT: begin
                if (i_start) begin
                    cnt_d   = 9'd0;
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    if (sum_s > CNT_FULL) begin
                        cnt_d = CNT_FULL[8:0];
                        err_d = 1'b1;
                    end else begin
                        cnt_d = sum_s[8:0];
                    end
                    if (bad_lane_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_d;
                    end
                    // Beats arriving with done are counted before the length check.
                    if (i_done) begin
                        if (cnt_d != CNT_FULL[8:0]) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_d;
                        end
                        valid_d = (cnt_d == CNT_FULL[8:0]) && !err_d;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                cnt_d   = 9'd0;
                err_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Status registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q   <= 9'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == ST_COLLECT);
        end
    end

    // Coefficient storage; raw signed codes, cleared on reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int a = 0; a < N_COEF; a++) begin
                mem_q[a] <= {CW{1'b0}};
            end
        end else begin
            for (int j = 0; j < LANES; j++) begin
                if (lane_wen_s[j]) begin
                    mem_q[lane_addr_s[j]] <= lane_val_s[j];
                end
            end
        end
    end

    cbd_to_modq #(
        .Q  (Q),
        .CW (CW)
    ) u_map (
        .coef_i (mem_q[i_rd_addr]),
        .modq_o (rd_map_s)
    );

    // Read port: same-cycle writes are not forwarded, so the old value returns.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_data_q  <= 12'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= i_rd_en;
            if (i_rd_en) begin
                rd_data_q <= rd_map_s;
            end
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_cnt      = cnt_q;
    assign o_busy     = busy_q;
    assign o_valid    = valid_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_cbd_poly_collector.sv
// -----------------------------------------------------------------------------
// tb_cbd_poly_collector
// Randomised bench with a behavioural model of the collector (integer count,
// integer coefficient array, sticky flags) compared against the DUT on every
// falling edge, plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_cbd_poly_collector;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [20:0] coef;
    logic [2:0]  num;
    logic        done;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [11:0] o_rd_data;
    logic        o_rd_valid;
    logic [8:0]  o_cnt;
    logic        o_busy;
    logic        o_valid;
    logic        o_err;

    cbd_poly_collector dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (start),
        .i_coef     (coef),
        .i_num      (num),
        .i_done     (done),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_cnt      (o_cnt),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 idle, 1 collecting, 2 ready.
    int m_mem [256];
    int m_cnt;
    int m_state;
    bit m_err;
    bit m_valid;
    bit m_rdv;
    int m_rdd;

    int checks   = 0;
    int failures = 0;
    bit dir_rd   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_val(input logic [20:0] c, input int j);
        logic [2:0] l;
        l = c[3*j +: 3];
        return l[2] ? int'(l) - 8 : int'(l);
    endfunction

    function automatic int map_q(input int v);
        return (v < 0) ? 3329 + v : v;
    endfunction

    function automatic int pat(input int mode, input int idx);
        case (mode)
            0:       return (idx % 7) - 3;
            2:       return (idx % 5) - 2;
            3:       return (idx == 10) ? -4 : (idx % 7) - 3;
            4:       return ($urandom_range(0, 15) == 0) ? -4 : int'($urandom_range(0, 6)) - 3;
            default: return int'($urandom_range(0, 6)) - 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 256; a++) m_mem[a] = 0;
        m_cnt = 0; m_state = 0; m_err = 0; m_valid = 0; m_rdv = 0; m_rdd = 0;
    endtask

    task automatic model_step();
        int n;
        int v;
        if (!rstn) return;
        m_rdv = rd_en;
        if (rd_en) m_rdd = map_q(m_mem[rd_addr]);
        if (start) begin
            m_state = 1; m_cnt = 0; m_err = 0; m_valid = 0;
        end else if (m_state == 1) begin
            n = int'(num);
            for (int j = 0; j < n; j++) begin
                v = lane_val(coef, j);
                if (v == -4) m_err = 1;
                if (m_cnt + j < 256) m_mem[m_cnt + j] = v;
                else m_err = 1;
            end
            m_cnt = (m_cnt + n > 256) ? 256 : m_cnt + n;
            if (done) begin
                if (m_cnt != 256) m_err = 1;
                m_valid = (m_cnt == 256) && !m_err;
                m_state = 2;
            end
        end
    endtask

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("cnt",      int'(o_cnt),      m_cnt);
            check("busy",     int'(o_busy),     int'(m_state == 1));
            check("valid",    int'(o_valid),    int'(m_valid));
            check("err",      int'(o_err),      int'(m_err));
            check("rd_valid", int'(o_rd_valid), int'(m_rdv));
            check("rd_data",  int'(o_rd_data),  m_rdd);
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_read();
        if (!dir_rd) begin
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic set_idle();
        start = 1'b0; done = 1'b0; num = 3'd0; coef = 21'd0;
        rand_read();
    endtask

    task automatic idle_step();
        set_idle();
        step();
    endtask

    // Invalid lanes carry 3'b100 so a leak into storage or err shows up.
    task automatic beat(input int n, input int mode, input bit d);
        for (int j = 0; j < 7; j++) begin
            if (j < n) coef[3*j +: 3] = 3'(pat(mode, m_cnt + j));
            else       coef[3*j +: 3] = 3'b100;
        end
        num = 3'(n); done = d; start = 1'b0;
        rand_read();
        step();
        done = 1'b0;
    endtask

    task automatic pulse_start();
        set_idle();
        start = 1'b1;
        num   = 3'($urandom_range(0, 7));
        coef  = 21'($urandom);
        step();
        start = 1'b0;
    endtask

    task automatic done_only();
        set_idle();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic read_lit(input int a, input int exp, input string name);
        set_idle();
        rd_en = 1'b1; rd_addr = 8'(a);
        dir_rd = 1'b1;
        step();
        dir_rd = 1'b0;
        check(name, int'(o_rd_data), exp);
        check({name, "_v"}, int'(o_rd_valid), 1);
    endtask

    task automatic nominal_body(input int mode);
        for (int b = 0; b < 25; b++) beat(7, mode, 1'b0);
        beat(6, mode, 1'b0);
        for (int b = 0; b < 10; b++) beat(7, mode, 1'b0);
        beat(5, mode, 1'b1);
    endtask

    initial begin
        int target;
        rstn = 1'b0;
        start = 1'b0; done = 1'b0; num = 3'd0; coef = 21'd0;
        rd_en = 1'b0; rd_addr = 8'd0;
        model_reset();
        #12 rstn = 1'b1;
        @(negedge clk);
        check("rst_cnt",  int'(o_cnt), 0);
        check("rst_busy", int'(o_busy), 0);

        // Nominal burst with the sampler's usual split; done on the last beat.
        pulse_start();
        nominal_body(0);
        check("nom_cnt",   int'(o_cnt),   256);
        check("nom_valid", int'(o_valid), 1);
        check("nom_err",   int'(o_err),   0);
        read_lit(0,   3326, "nom_rd0");
        read_lit(3,   0,    "nom_rd3");
        read_lit(6,   3,    "nom_rd6");
        read_lit(255, 0,    "nom_rd255");

        // Short stream of 255.
        pulse_start();
        for (int b = 0; b < 36; b++) beat(7, 1, 1'b0);
        beat(3, 1, 1'b0);
        done_only();
        check("short_cnt",   int'(o_cnt),   255);
        check("short_err",   int'(o_err),   1);
        check("short_valid", int'(o_valid), 0);

        // Overflow: 259 offered, 256 kept.
        pulse_start();
        for (int b = 0; b < 37; b++) beat(7, 2, 1'b0);
        check("ovf_cnt", int'(o_cnt), 256);
        check("ovf_err", int'(o_err), 1);
        done_only();
        read_lit(255, 3327, "ovf_rd255");

        // Illegal -4 at index 10.
        pulse_start();
        nominal_body(3);
        check("ill_err",   int'(o_err),   1);
        check("ill_valid", int'(o_valid), 0);
        read_lit(10, 3325, "ill_rd10");

        // Restart at 140 with err already set, then a clean burst.
        pulse_start();
        for (int b = 0; b < 20; b++) beat(7, 3, 1'b0);
        check("rs_cnt140", int'(o_cnt), 140);
        check("rs_err1",   int'(o_err), 1);
        pulse_start();
        check("rs_cnt0", int'(o_cnt), 0);
        check("rs_err0", int'(o_err), 0);
        nominal_body(0);
        check("rs_valid", int'(o_valid), 1);

        // Randomised bursts, random splits, idle beats and -4 codes.
        for (int it = 0; it < 16; it++) begin
            pulse_start();
            target = int'($urandom_range(250, 262));
            while (m_cnt < target && m_cnt < 256) begin
                beat(int'($urandom_range(0, 7)), (it % 2 == 1) ? 4 : 1, 1'b0);
            end
            done_only();
            for (int k = 0; k < 3; k++) idle_step();
        end

        // Asynchronous reset mid-collection.
        pulse_start();
        for (int b = 0; b < 10; b++) beat(7, 0, 1'b0);
        check("pre_rst_cnt", int'(o_cnt), 70);
        read_lit(0, 3326, "pre_rst_rd0");
        set_idle();
        #2 rstn = 1'b0;
        #1;
        check("arst_cnt",      int'(o_cnt),      0);
        check("arst_busy",     int'(o_busy),     0);
        check("arst_valid",    int'(o_valid),    0);
        check("arst_err",      int'(o_err),      0);
        check("arst_rd_valid", int'(o_rd_valid), 0);
        check("arst_rd_data",  int'(o_rd_data),  0);
        model_reset();
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        read_lit(int'($urandom_range(0, 255)), 0, "post_rst_rd");
        idle_step();

        // Same-cycle read and write of index 0 returns the old value.
        pulse_start();
        dir_rd = 1'b1; rd_en = 1'b1; rd_addr = 8'd0;
        beat(7, 0, 1'b0);
        dir_rd = 1'b0;
        check("rw_old", int'(o_rd_data), 0);
        read_lit(0, 3326, "rw_new");
        idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
